serial_sub_ctrl: RTL



---
 rtl/serial_sub_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor that walks a single full_subtractor
// cell across WIDTH-bit operands, LSB first, computing a_in - b_in - bin_in.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a_in, b_in, bin_in)
//   out_valid/out_ready result handshake (diff_out, bout_out)
//   busy                high while an operation is RUNning or waiting in DONE
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. in_ready, out_valid and busy are pure decodes
// of the state register, so neither ready nor valid depends combinationally on
// the other side's inputs. A presented result (out_valid, diff_out, bout_out)
// is held stable until it is accepted.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~(a ^ b) & c);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_ff;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic load;
  logic step;
  logic last_step;
  logic cell_diff;
  logic cell_borrow;

  full_subtractor u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .c      (borrow_ff),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  // count holds the number of bit-steps already done; the step taken while
  // count == WIDTH-1 is the last of WIDTH steps.
  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The working shift registers change on every accept and step, so the
  // visible result lives in separate output registers that are loaded only on
  // the final step. That keeps diff_out/bout_out stable through DONE and after
  // the return to IDLE until the next result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow_ff <= 1'b0;
      count     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
    end else if (load) begin
      a_sr      <= a_in;
      b_sr      <= b_in;
      borrow_ff <= bin_in;
      count     <= '0;
    end else if (step) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      borrow_ff <= cell_borrow;
      res_sr    <= {cell_diff, res_sr[WIDTH-1:1]};
      count     <= count + CW'(1);
      if (last_step) begin
        diff_q <= {cell_diff, res_sr[WIDTH-1:1]};
        bout_q <= cell_borrow;
      end
    end
  end

  assign diff_out = diff_q;
  assign bout_out = bout_q;

endmodule
